// File: rtl/div_front.sv
// Request-side front end for the cached reciprocal divider: operand magnitude
// conversion, one divider operation per request, quotient correction and sign fix-up.
module div_front #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [31:0]      req_addr,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    output logic [31:0]      div_addr,
    input  logic [31:0]      div_q,
    input  logic [31:0]      div_r,
    input  logic             div_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dbz,
    output logic             rsp_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPR, FIX, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t      state;
    logic [CW-1:0] cnt;
    logic [1:0]  op;
    logic        sa, sb;
    logic [31:0] qm, rm;
    logic [31:0] a_mag, b_mag, q_fix, r_fix, q_out, r_out;
    logic        bump;

    always_comb begin
        a_mag = (req_a[31] & req_op[0]) ? ~req_a + 32'd1 : req_a;
        b_mag = (req_b[31] & req_op[0]) ? ~req_b + 32'd1 : req_b;
        // The divider may under-estimate the quotient by one; fold it back here.
        bump  = (rm >= div_b);
        q_fix = bump ? qm + 32'd1 : qm;
        r_fix = bump ? rm - div_b : rm;
        q_out = (sa ^ sb) ? ~q_fix + 32'd1 : q_fix;
        r_out = sa ? ~r_fix + 32'd1 : r_fix;
    end

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            qm        <= '0;
            rm        <= '0;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            div_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_dbz   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    op       <= req_op;
                    rsp_tag  <= req_tag;
                    sa       <= req_a[31] & req_op[0];
                    sb       <= req_b[31] & req_op[0];
                    div_a    <= a_mag;
                    div_b    <= b_mag;
                    div_addr <= req_addr;
                    if (req_b == 32'd0) begin
                        rsp_data  <= req_op[1] ? req_a : 32'hFFFF_FFFF;
                        rsp_dbz   <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        div_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                // cnt counts WAIT cycles; the error response lands TIMEOUT cycles after the start pulse.
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (div_done) begin
                        qm    <= div_q;
                        state <= CAPR;
                    end else if (cnt == CW'(TIMEOUT - 2)) begin
                        rsp_data  <= '0;
                        rsp_dbz   <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                CAPR: begin
                    rm    <= div_r;
                    state <= FIX;
                end
                FIX: begin
                    rsp_data  <= op[1] ? r_out : q_out;
                    rsp_dbz   <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_front.sv
// Directed bench for div_front with a behavioural divider stub (exact, off-by-one, silent).
module tb_div_front;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a, req_b, req_addr;
    logic [TAG_W-1:0] req_tag;
    logic             div_start;
    logic [31:0]      div_a, div_b, div_addr, div_q, div_r;
    logic             div_done;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_dbz, rsp_err;

    div_front #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_addr(req_addr), .req_tag(req_tag),
        .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_addr(div_addr),
        .div_q(div_q), .div_r(div_r), .div_done(div_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    int starts  = 0;
    int stub_mode = 0;          // 0 exact, 1 quotient one low, 2 never done
    logic [31:0] seen_a, seen_b, seen_addr;

    always @(posedge clk) if (div_start === 1'b1) starts <= starts + 1;

    // Divider stub: done three cycles into WAIT, q in the done cycle, r the cycle after.
    initial begin
        logic [31:0] q, r;
        div_done = 1'b0; div_q = '0; div_r = '0;
        forever begin
            @(posedge clk); #1;
            if (div_start === 1'b1 && stub_mode != 2) begin
                seen_a = div_a; seen_b = div_b; seen_addr = div_addr;
                q = div_a / div_b;
                r = div_a % div_b;
                if (stub_mode == 1 && q != 0) begin q = q - 1; r = r + div_b; end
                repeat (3) @(posedge clk);
                #1 div_done = 1'b1; div_q = q; div_r = 32'hDEAD_BEEF;
                @(posedge clk);
                #1 div_done = 1'b0; div_q = 32'hDEAD_BEEF; div_r = r;
                @(posedge clk);
                #1 div_r = '0; div_q = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; return cycles from accept to rsp_valid (cycle 0 = accept cycle).
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] addr, input logic [TAG_W-1:0] tag, output int lat);
        req_op = op; req_a = a; req_b = b; req_addr = addr; req_tag = tag;
        req_valid = 1'b1;
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (rsp_valid !== 1'b1) chk("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        int lat;
        send(op, a, b, 32'h40, 4'h5, lat);
        chk({tag, "_data"}, rsp_data, exp);
        chk({tag, "_dbz"}, {31'd0, rsp_dbz}, 32'd0);
        finish_rsp();
    endtask

    initial begin
        int lat, s0;
        logic [31:0] d0;
        logic [TAG_W-1:0] t0;
        logic stable;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0; req_addr = '0; req_tag = '0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;

        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_div_start", {31'd0, div_start}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_div_a", div_a, 32'd0);

        // 1: unsigned, with latency check and cached-path repeat
        send(2'b00, 32'd100, 32'd7, 32'h40, 4'h3, lat);
        chk("divu_data", rsp_data, 32'd14);
        chk("divu_tag", {28'd0, rsp_tag}, 32'd3);
        chk("divu_dbz", {31'd0, rsp_dbz}, 32'd0);
        chk("divu_latency", lat, 32'd7);
        chk("divu_addr", seen_addr, 32'h40);
        finish_rsp();
        run("modu", 2'b10, 32'd100, 32'd7, 32'd2);
        run("divu_rep", 2'b00, 32'd100, 32'd7, 32'd14);
        run("modu_rep", 2'b10, 32'd100, 32'd7, 32'd2);

        // 2: signed
        run("div_neg", 2'b01, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        chk("div_neg_mag_a", seen_a, 32'd100);
        run("mod_neg_a", 2'b11, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        run("mod_neg_b", 2'b11, 32'd100, 32'hFFFF_FFF9, 32'd2);
        chk("mod_neg_b_mag_b", seen_b, 32'd7);

        // 3: divide by zero
        s0 = starts;
        send(2'b01, 32'd5, 32'd0, 32'h0, 4'h9, lat);
        chk("dbz_latency", lat, 32'd1);
        chk("dbz_div_data", rsp_data, 32'hFFFF_FFFF);
        chk("dbz_flag", {31'd0, rsp_dbz}, 32'd1);
        finish_rsp();
        send(2'b10, 32'd5, 32'd0, 32'h0, 4'h9, lat);
        chk("dbz_modu_data", rsp_data, 32'd5);
        finish_rsp();
        chk("dbz_no_start", starts - s0, 32'd0);

        // 4: overflow and quotient correction
        run("div_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("mod_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        stub_mode = 1;
        run("fix_divu", 2'b00, 32'd100, 32'd7, 32'd14);
        run("fix_modu", 2'b10, 32'd100, 32'd7, 32'd2);
        run("fix_div", 2'b01, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        stub_mode = 0;

        // 5: response backpressure
        rsp_ready = 1'b0;
        send(2'b00, 32'd50, 32'd6, 32'h80, 4'hA, lat);
        d0 = rsp_data; t0 = rsp_tag; stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_tag !== t0 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        chk("bp_data", d0, 32'd8);
        chk("bp_tag", {28'd0, t0}, 32'hA);
        finish_rsp();
        chk("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
        run("bp_next", 2'b10, 32'd50, 32'd6, 32'd2);

        // 6: timeout and reset mid-operation
        stub_mode = 2;
        send(2'b00, 32'd100, 32'd7, 32'h40, 4'h1, lat);
        chk("to_latency", lat, 32'(TIMEOUT + 1));
        chk("to_err", {31'd0, rsp_err}, 32'd1);
        chk("to_data", rsp_data, 32'd0);
        finish_rsp();
        req_op = 2'b00; req_a = 32'd9; req_b = 32'd2; req_tag = 4'h2; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_wait_req_ready", {31'd0, req_ready}, 32'd1);
        stub_mode = 0;
        repeat (3) @(posedge clk); #1;
        run("post_rst", 2'b00, 32'd9, 32'd2, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
